// File: rtl/nvme_pkg.sv
// nvme_pkg: shared definitions for the NVMe controller register block.
// Holds register byte offsets, the VS constant, the controller state enum,
// CC/CSTS field positions and a helper that builds the CAP value.
package nvme_pkg;

  // Register byte offsets (bits [1:0] of the bus address are ignored)
  localparam logic [15:0] REG_CAP_LO  = 16'h0000;
  localparam logic [15:0] REG_CAP_HI  = 16'h0004;
  localparam logic [15:0] REG_VS      = 16'h0008;
  localparam logic [15:0] REG_INTMS   = 16'h000C;
  localparam logic [15:0] REG_INTMC   = 16'h0010;
  localparam logic [15:0] REG_CC      = 16'h0014;
  localparam logic [15:0] REG_CSTS    = 16'h001C;
  localparam logic [15:0] REG_AQA     = 16'h0024;
  localparam logic [15:0] REG_ASQ_LO  = 16'h0028;
  localparam logic [15:0] REG_ASQ_HI  = 16'h002C;
  localparam logic [15:0] REG_ACQ_LO  = 16'h0030;
  localparam logic [15:0] REG_ACQ_HI  = 16'h0034;
  localparam logic [15:0] REG_DB_BASE = 16'h1000;

  localparam logic [31:0] NVME_VS = 32'h0001_0400;

  // CC fields: EN[0], CSS[6:4], MPS[10:7], AMS[13:11], SHN[15:14],
  // IOSQES[19:16], IOCQES[23:20]; everything else is reserved.
  localparam int CC_EN      = 0;
  localparam int CC_SHN_LSB = 14;
  localparam int CC_SHN_MSB = 15;
  localparam logic [31:0] CC_WMASK = 32'h00FF_FFF1;

  // CSTS fields: RDY[0], CFS[1], SHST[3:2]
  localparam int CSTS_RDY      = 0;
  localparam int CSTS_CFS      = 1;
  localparam int CSTS_SHST_LSB = 2;
  localparam int CSTS_SHST_MSB = 3;

  localparam logic [1:0] SHST_NONE = 2'd0;
  localparam logic [1:0] SHST_BUSY = 2'd1;
  localparam logic [1:0] SHST_DONE = 2'd2;

  // Queue base registers are 4 KiB aligned
  localparam logic [31:0] QBASE_LO_MASK = 32'hFFFF_F000;

  typedef enum logic [2:0] {
    ST_DISABLED  = 3'd0,
    ST_ENABLING  = 3'd1,
    ST_READY     = 3'd2,
    ST_DISABLING = 3'd3,
    ST_SHUTDOWN  = 3'd4
  } nvme_state_e;

  // CAP: MQES[15:0], CQR[16], TO[31:24], DSTRD[35:32], CSS NVM bit[37]
  function automatic logic [63:0] cap_value(input int unsigned qdepth,
                                            input int unsigned rdy_delay,
                                            input int unsigned dstrd);
    logic [63:0] c;
    c        = '0;
    c[15:0]  = 16'(qdepth - 1);
    c[16]    = 1'b1;
    c[31:24] = 8'((rdy_delay + 499) / 500);
    c[35:32] = 4'(dstrd);
    c[37]    = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/nvme_db_decode.sv
// nvme_db_decode: maps a bus byte address onto a doorbell.
// Doorbell n = 2*qid + is_cq lives at 0x1000 + n*(4 << DSTRD).
// Ports: addr (in, 16) -> hit, qid (6), is_cq. hit is 0 for addresses
// below 0x1000, for qids >= NUM_QP and for addresses that fall inside a
// stride slot but not on its first dword.
module nvme_db_decode
  import nvme_pkg::*;
#(
  parameter int NUM_QP = 4,
  parameter int DSTRD  = 0
) (
  input  logic [15:0] addr,
  output logic        hit,
  output logic [5:0]  qid,
  output logic        is_cq
);

  localparam int SHIFT = 2 + DSTRD;
  localparam logic [15:0] SLOT_MASK = 16'((1 << SHIFT) - 1);

  logic [15:0] off;
  logic [15:0] idx;
  logic [15:0] q_full;
  logic        aligned;

  always_comb begin
    off     = addr - REG_DB_BASE;
    idx     = off >> SHIFT;
    q_full  = idx >> 1;
    aligned = ((off & SLOT_MASK) & 16'hFFFC) == 16'h0000;
    hit     = (addr >= REG_DB_BASE) && aligned && (q_full < 16'(NUM_QP));
    qid     = q_full[5:0];
    is_cq   = idx[0];
  end

endmodule

// File: rtl/nvme_ctrl_regs.sv
// nvme_ctrl_regs: NVMe controller register file and enable/shutdown FSM.
// Ports: clk/reset_n (async, active-low); addr/wr_en/wr_data write port;
// rd_en -> rd_data/rd_valid one cycle later; fatal sets sticky CSTS.CFS;
// ctrl_en high in ENABLING/READY; db_* one-cycle doorbell pulse;
// aqa/asq/acq admin queue registers; dbg_state exposes the FSM state.
// Optional macro NVME_CTRL_REGS_INTMASK_EN adds INTMS/INTMC and int_mask.
module nvme_ctrl_regs
  import nvme_pkg::*;
#(
  parameter int NUM_QP    = 4,
  parameter int QDEPTH    = 64,
  parameter int DSTRD     = 0,
  parameter int RDY_DELAY = 8,
  parameter int SHN_DELAY = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  input  logic        fatal,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        ctrl_en,
  output logic        db_valid,
  output logic [5:0]  db_qid,
  output logic        db_is_cq,
  output logic [15:0] db_value,
  output logic [31:0] aqa,
  output logic [63:0] asq,
  output logic [63:0] acq,
`ifdef NVME_CTRL_REGS_INTMASK_EN
  output logic [31:0] int_mask,
`endif
  output nvme_state_e dbg_state
);

  localparam logic [63:0] CAP      = cap_value(QDEPTH, RDY_DELAY, DSTRD);
  localparam logic [31:0] RDY_LAST = 32'(RDY_DELAY - 1);
  localparam logic [31:0] SHN_LAST = 32'(SHN_DELAY - 1);

  nvme_state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        rdy_q, rdy_d;
  logic [1:0]  shst_q, shst_d;
  logic        cfs_q, cfs_d;
  logic [31:0] cc_q, cc_d;
  logic [31:0] aqa_q, aqa_d;
  logic [63:0] asq_q, asq_d;
  logic [63:0] acq_q, acq_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        db_valid_q, db_valid_d;
  logic [5:0]  db_qid_q, db_qid_d;
  logic        db_is_cq_q, db_is_cq_d;
  logic [15:0] db_value_q, db_value_d;
`ifdef NVME_CTRL_REGS_INTMASK_EN
  logic [31:0] int_mask_q, int_mask_d;
`endif

  logic [15:0] waddr;
  logic [31:0] csts;
  logic [31:0] rd_mux;
  logic        q_wr_ok;
  logic        db_hit;
  logic [5:0]  db_qid_w;
  logic        db_is_cq_w;
  logic        db_fire;

  assign waddr = {addr[15:2], 2'b00};
  assign csts  = {28'h0, shst_q, cfs_q, rdy_q};

  nvme_db_decode #(.NUM_QP(NUM_QP), .DSTRD(DSTRD)) u_db_decode (
    .addr  (addr),
    .hit   (db_hit),
    .qid   (db_qid_w),
    .is_cq (db_is_cq_w)
  );

  // Read mux sees only current flop values, so a same-cycle write is not
  // visible to the read (pre-write value is returned).
  always_comb begin
    rd_mux = '0;
    case (waddr)
      REG_CAP_LO: rd_mux = CAP[31:0];
      REG_CAP_HI: rd_mux = CAP[63:32];
      REG_VS:     rd_mux = NVME_VS;
`ifdef NVME_CTRL_REGS_INTMASK_EN
      REG_INTMS:  rd_mux = int_mask_q;
      REG_INTMC:  rd_mux = int_mask_q;
`endif
      REG_CC:     rd_mux = cc_q;
      REG_CSTS:   rd_mux = csts;
      REG_AQA:    rd_mux = aqa_q;
      REG_ASQ_LO: rd_mux = asq_q[31:0];
      REG_ASQ_HI: rd_mux = asq_q[63:32];
      REG_ACQ_LO: rd_mux = acq_q[31:0];
      REG_ACQ_HI: rd_mux = acq_q[63:32];
      default:    rd_mux = '0;
    endcase
  end

  // Register writes, read response and doorbell pulse
  always_comb begin
    cc_d    = cc_q;
    aqa_d   = aqa_q;
    asq_d   = asq_q;
    acq_d   = acq_q;
    cfs_d   = cfs_q | fatal;
    // Admin queue registers are frozen once the controller is enabled or
    // still reports ready.
    q_wr_ok = !cc_q[CC_EN] && !rdy_q;
`ifdef NVME_CTRL_REGS_INTMASK_EN
    int_mask_d = int_mask_q;
`endif
    if (wr_en) begin
      case (waddr)
        REG_CC:     cc_d = wr_data & CC_WMASK;
        REG_AQA:    if (q_wr_ok) aqa_d = wr_data;
        REG_ASQ_LO: if (q_wr_ok) asq_d[31:0] = wr_data & QBASE_LO_MASK;
        REG_ASQ_HI: if (q_wr_ok) asq_d[63:32] = wr_data;
        REG_ACQ_LO: if (q_wr_ok) acq_d[31:0] = wr_data & QBASE_LO_MASK;
        REG_ACQ_HI: if (q_wr_ok) acq_d[63:32] = wr_data;
`ifdef NVME_CTRL_REGS_INTMASK_EN
        REG_INTMS:  int_mask_d = int_mask_q | wr_data;
        REG_INTMC:  int_mask_d = int_mask_q & ~wr_data;
`endif
        default: ;
      endcase
    end

    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? rd_mux : 32'h0;

    db_fire    = wr_en && db_hit && (state_q == ST_READY) &&
                 ({16'h0, wr_data[15:0]} < 32'(QDEPTH));
    db_valid_d = db_fire;
    db_qid_d   = db_fire ? db_qid_w : 6'h0;
    db_is_cq_d = db_fire ? db_is_cq_w : 1'b0;
    db_value_d = db_fire ? wr_data[15:0] : 16'h0;
  end

  // FSM next state. Transitions look at cc_d so the FSM reacts in the same
  // edge that captures the CC write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    shst_d  = shst_q;
    case (state_q)
      ST_DISABLED: begin
        if (cc_d[CC_EN]) begin
          state_d = ST_ENABLING;
          cnt_d   = '0;
        end
      end
      ST_ENABLING: begin
        if (!cc_d[CC_EN]) begin
          state_d = ST_DISABLING;
          cnt_d   = '0;
        end else if (cnt_q == RDY_LAST) begin
          // Hold at the terminal count while a fatal error is flagged
          if (!(fatal || cfs_q)) begin
            state_d = ST_READY;
            rdy_d   = 1'b1;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_READY: begin
        if (!cc_d[CC_EN]) begin
          state_d = ST_DISABLING;
          cnt_d   = '0;
        end else if (cc_d[CC_SHN_MSB:CC_SHN_LSB] != 2'b00) begin
          state_d = ST_SHUTDOWN;
          shst_d  = SHST_BUSY;
          cnt_d   = '0;
        end
      end
      ST_DISABLING: begin
        if (cnt_q == RDY_LAST) begin
          state_d = ST_DISABLED;
          rdy_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_SHUTDOWN: begin
        if (!cc_d[CC_EN]) begin
          state_d = ST_DISABLING;
          shst_d  = SHST_NONE;
          cnt_d   = '0;
        end else if (shst_q == SHST_BUSY) begin
          if (cnt_q == SHN_LAST) shst_d = SHST_DONE;
          else                   cnt_d  = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_DISABLED;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    ctrl_en   = (state_q == ST_ENABLING) || (state_q == ST_READY);
    dbg_state = state_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_DISABLED;
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      shst_q     <= SHST_NONE;
      cfs_q      <= 1'b0;
      cc_q       <= '0;
      aqa_q      <= '0;
      asq_q      <= '0;
      acq_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      db_valid_q <= 1'b0;
      db_qid_q   <= '0;
      db_is_cq_q <= 1'b0;
      db_value_q <= '0;
`ifdef NVME_CTRL_REGS_INTMASK_EN
      int_mask_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdy_q      <= rdy_d;
      shst_q     <= shst_d;
      cfs_q      <= cfs_d;
      cc_q       <= cc_d;
      aqa_q      <= aqa_d;
      asq_q      <= asq_d;
      acq_q      <= acq_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      db_valid_q <= db_valid_d;
      db_qid_q   <= db_qid_d;
      db_is_cq_q <= db_is_cq_d;
      db_value_q <= db_value_d;
`ifdef NVME_CTRL_REGS_INTMASK_EN
      int_mask_q <= int_mask_d;
`endif
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign db_valid = db_valid_q;
  assign db_qid   = db_qid_q;
  assign db_is_cq = db_is_cq_q;
  assign db_value = db_value_q;
  assign aqa      = aqa_q;
  assign asq      = asq_q;
  assign acq      = acq_q;
`ifdef NVME_CTRL_REGS_INTMASK_EN
  assign int_mask = int_mask_q;
`endif

endmodule

// File: tb/tb_nvme_ctrl_regs.sv
// tb_nvme_ctrl_regs: directed bench for nvme_ctrl_regs with default
// parameters. Inputs change 1 ns after the rising edge; outputs are
// sampled at the same point. Honours NVME_CTRL_REGS_INTMASK_EN.
module tb_nvme_ctrl_regs;
  import nvme_pkg::*;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] addr    = '0;
  logic        wr_en   = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_en   = 1'b0;
  logic        fatal   = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        ctrl_en;
  logic        db_valid;
  logic [5:0]  db_qid;
  logic        db_is_cq;
  logic [15:0] db_value;
  logic [31:0] aqa;
  logic [63:0] asq;
  logic [63:0] acq;
  nvme_state_e dbg_state;
`ifdef NVME_CTRL_REGS_INTMASK_EN
  logic [31:0] int_mask;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nvme_ctrl_regs #(
    .NUM_QP(4), .QDEPTH(64), .DSTRD(0), .RDY_DELAY(8), .SHN_DELAY(16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .addr      (addr),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .fatal     (fatal),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .ctrl_en   (ctrl_en),
    .db_valid  (db_valid),
    .db_qid    (db_qid),
    .db_is_cq  (db_is_cq),
    .db_value  (db_value),
    .aqa       (aqa),
    .asq       (asq),
    .acq       (acq),
`ifdef NVME_CTRL_REGS_INTMASK_EN
    .int_mask  (int_mask),
`endif
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [15:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic [15:0] a, output logic [31:0] d);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("rd_valid", 64'(rd_valid), 64'd1);
    d = rd_data;
  endtask

  task automatic rw_same(input logic [15:0] a, input logic [31:0] wd,
                         output logic [31:0] d);
    addr = a; wr_data = wd; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("rw_rd_valid", 64'(rd_valid), 64'd1);
    d = rd_data;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl_en"},  64'(ctrl_en),   64'd0);
    check({tag, "_rd_valid"}, 64'(rd_valid),  64'd0);
    check({tag, "_rd_data"},  64'(rd_data),   64'd0);
    check({tag, "_db_valid"}, 64'(db_valid),  64'd0);
    check({tag, "_db_qid"},   64'(db_qid),    64'd0);
    check({tag, "_db_is_cq"}, 64'(db_is_cq),  64'd0);
    check({tag, "_db_value"}, 64'(db_value),  64'd0);
    check({tag, "_aqa"},      64'(aqa),       64'd0);
    check({tag, "_asq"},      asq,            64'd0);
    check({tag, "_acq"},      acq,            64'd0);
    check({tag, "_state"},    64'(dbg_state), 64'(ST_DISABLED));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] d;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;
    tick();

    // Read-only registers and unmapped space
    read_reg(REG_CAP_LO, d); check("cap_lo", 64'(d), 64'h0101_003F);
    read_reg(REG_CAP_HI, d); check("cap_hi", 64'(d), 64'h0000_0020);
    read_reg(REG_VS, d);     check("vs",     64'(d), 64'h0001_0400);
    tick();
    check("idle_rd_valid", 64'(rd_valid), 64'd0);
    check("idle_rd_data",  64'(rd_data),  64'd0);
    write_reg(16'h0018, 32'hFFFF_FFFF);
    read_reg(16'h0018, d);   check("unmapped_18",  64'(d), 64'd0);
    read_reg(16'h0800, d);   check("unmapped_800", 64'(d), 64'd0);

    // Interrupt mask registers
`ifdef NVME_CTRL_REGS_INTMASK_EN
    write_reg(REG_INTMS, 32'h0000_0003);
    write_reg(REG_INTMC, 32'h0000_0001);
    read_reg(REG_INTMS, d);  check("intms_rd", 64'(d), 64'h2);
    read_reg(REG_INTMC, d);  check("intmc_rd", 64'(d), 64'h2);
    check("int_mask", 64'(int_mask), 64'h2);
`else
    write_reg(REG_INTMS, 32'h0000_0003);
    read_reg(REG_INTMS, d);  check("intms_absent", 64'(d), 64'd0);
    write_reg(REG_INTMC, 32'h0000_0001);
    read_reg(REG_INTMC, d);  check("intmc_absent", 64'(d), 64'd0);
`endif

    // Admin queue registers while DISABLED
    write_reg(REG_AQA,    32'h001F_001F);
    write_reg(REG_ASQ_LO, 32'h1234_5FFF);
    write_reg(REG_ASQ_HI, 32'h0000_0001);
    write_reg(REG_ACQ_LO, 32'hABCD_E123);
    write_reg(REG_ACQ_HI, 32'h0000_0002);
    read_reg(REG_ASQ_LO, d); check("asq_lo_disabled", 64'(d), 64'h1234_5000);
    read_reg(REG_ACQ_LO, d); check("acq_lo_disabled", 64'(d), 64'hABCD_E000);
    check("asq_out", asq, 64'h0000_0001_1234_5000);
    check("acq_out", acq, 64'h0000_0002_ABCD_E000);
    check("aqa_out", 64'(aqa), 64'h001F_001F);

    // Simultaneous read and write returns the pre-write value
    rw_same(REG_AQA, 32'h003F_003F, d);
    check("rw_pre_write", 64'(d), 64'h001F_001F);
    read_reg(REG_AQA, d);    check("rw_post_write", 64'(d), 64'h003F_003F);

    // Doorbell while not READY is dropped
    write_reg(16'h100C, 32'h0000_0005);
    check("db_disabled", 64'(db_valid), 64'd0);

    // Enable: ctrl_en next cycle, RDY exactly 8 cycles after the write
    write_reg(REG_CC, 32'h0046_0001);
    check("en_ctrl_en", 64'(ctrl_en), 64'd1);
    check("en_state", 64'(dbg_state), 64'(ST_ENABLING));
    for (int i = 0; i < 8; i++) begin
      read_reg(REG_CSTS, d); check("csts_enabling", 64'(d), 64'h0);
    end
    read_reg(REG_CSTS, d);   check("csts_ready", 64'(d), 64'h1);
    check("ready_ctrl_en", 64'(ctrl_en), 64'd1);
    check("ready_state", 64'(dbg_state), 64'(ST_READY));
    read_reg(REG_CC, d);     check("cc_rd", 64'(d), 64'h0046_0001);

    // Doorbells in READY
    write_reg(16'h100C, 32'h0000_0005);
    check("db1_valid", 64'(db_valid), 64'd1);
    check("db1_qid",   64'(db_qid),   64'd1);
    check("db1_is_cq", 64'(db_is_cq), 64'd1);
    check("db1_value", 64'(db_value), 64'd5);
    tick();
    check("db1_pulse_end", 64'(db_valid), 64'd0);
    write_reg(16'h1000, 32'h0000_0040);
    check("db_too_big", 64'(db_valid), 64'd0);
    write_reg(16'h1000, 32'h0000_003F);
    check("db_max_valid", 64'(db_valid), 64'd1);
    check("db_max_qid",   64'(db_qid),   64'd0);
    check("db_max_is_cq", 64'(db_is_cq), 64'd0);
    check("db_max_value", 64'(db_value), 64'h3F);
    write_reg(16'h101C, 32'h0000_0007);
    check("db_last_valid", 64'(db_valid), 64'd1);
    check("db_last_qid",   64'(db_qid),   64'd3);
    check("db_last_is_cq", 64'(db_is_cq), 64'd1);
    write_reg(16'h1020, 32'h0000_0001);
    check("db_qid_range", 64'(db_valid), 64'd0);
    read_reg(16'h100C, d);   check("db_read", 64'(d), 64'd0);

    // Admin queue writes ignored while READY
    write_reg(REG_ASQ_LO, 32'h1234_5FFF);
    write_reg(REG_AQA, 32'h0000_0000);
    read_reg(REG_ASQ_LO, d); check("asq_ready_locked", 64'(d), 64'h1234_5000);
    check("aqa_ready_locked", 64'(aqa), 64'h003F_003F);

    // Shutdown: SHST=1 then 2 after 16 cycles
    write_reg(REG_CC, 32'h0046_4001);
    check("shn_state", 64'(dbg_state), 64'(ST_SHUTDOWN));
    check("shn_ctrl_en", 64'(ctrl_en), 64'd0);
    for (int i = 0; i < 16; i++) begin
      read_reg(REG_CSTS, d); check("csts_shst_busy", 64'(d), 64'h5);
    end
    read_reg(REG_CSTS, d);   check("csts_shst_done", 64'(d), 64'h9);

    // Disable from SHUTDOWN: SHST cleared, RDY drops after 8 cycles
    write_reg(REG_CC, 32'h0000_0000);
    check("dis_state", 64'(dbg_state), 64'(ST_DISABLING));
    for (int i = 0; i < 8; i++) begin
      read_reg(REG_CSTS, d); check("csts_disabling", 64'(d), 64'h1);
    end
    read_reg(REG_CSTS, d);   check("csts_disabled", 64'(d), 64'h0);
    check("disabled_state", 64'(dbg_state), 64'(ST_DISABLED));
    read_reg(REG_ASQ_LO, d); check("asq_retained", 64'(d), 64'h1234_5000);
    check("aqa_retained", 64'(aqa), 64'h003F_003F);

    // ENABLING aborted by clearing EN goes through DISABLING
    write_reg(REG_CC, 32'h0000_0001);
    tick();
    write_reg(REG_CC, 32'h0000_0000);
    check("abort_state", 64'(dbg_state), 64'(ST_DISABLING));
    repeat (7) tick();
    check("abort_still_disabling", 64'(dbg_state), 64'(ST_DISABLING));
    tick();
    check("abort_done", 64'(dbg_state), 64'(ST_DISABLED));

    // Fatal holds the controller in ENABLING and sets CFS
    fatal = 1'b1;
    write_reg(REG_CC, 32'h0000_0001);
    repeat (12) tick();
    check("fatal_state", 64'(dbg_state), 64'(ST_ENABLING));
    read_reg(REG_CSTS, d);   check("fatal_csts", 64'(d), 64'h2);
    fatal = 1'b0;

    // Reset clears CFS and everything else
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    read_reg(REG_CSTS, d);   check("csts_after_reset", 64'(d), 64'h0);

    // Reset in ENABLING cycle 4 aborts the count immediately
    write_reg(REG_CC, 32'h0046_0001);
    repeat (3) tick();
    check("pre_reset_state", 64'(dbg_state), 64'(ST_ENABLING));
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    tick();
    reset_n = 1'b1;
    read_reg(REG_CSTS, d);   check("csts_post_abort", 64'(d), 64'h0);
    read_reg(REG_CC, d);     check("cc_post_abort",   64'(d), 64'h0);
    repeat (10) tick();
    check("stays_disabled", 64'(dbg_state), 64'(ST_DISABLED));
    check("stays_ctrl_en",  64'(ctrl_en),   64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
